// File: rtl/block_scroller_if.sv
// Playfield bus between the block scroller (slave) and the judge/display
// side (master). The pause line exists only in builds with PAUSE_EN defined.
interface block_scroller_if;
  logic        start;
  logic        gameover;
`ifdef PAUSE_EN
  logic        pause;
`endif
  logic [63:0] blocks;
  logic        step;
  logic [15:0] score;
  logic        running;

  modport master (
`ifdef PAUSE_EN
    output pause,
`endif
    output start,
    output gameover,
    input  blocks,
    input  step,
    input  score,
    input  running
  );

  modport slave (
`ifdef PAUSE_EN
    input  pause,
`endif
    input  start,
    input  gameover,
    output blocks,
    output step,
    output score,
    output running
  );
endinterface

// File: rtl/block_scroller.sv
// Falling-block playfield sequencer: 8x8 field that steps down one row per
// speed tick, feeds alternating random/empty rows in at the top, keeps a
// saturating score and shortens the tick period every 8 points.
// Optional feature macro: PAUSE_EN (adds a pause input that stalls stepping).
module block_scroller #(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned MIN_DIV   = 5_000_000,
  parameter int unsigned STEP_DIV  = 2_000_000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  block_scroller_if.slave bus
);

  // An all-zero LFSR would lock up, so a zero seed is swapped for a legal one.
  localparam logic [7:0]  SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h1D : LFSR_SEED;
  localparam logic [31:0] TICK_C   = TICK_DIV;
  localparam logic [31:0] MIN_C    = MIN_DIV;
  localparam logic [31:0] STEP_C   = STEP_DIV;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t      state_reg, state_next;
  logic [63:0] blocks_reg, blocks_next;
  logic [15:0] score_reg, score_next;
  logic        step_reg, step_next;
  logic        running_reg, running_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] div_reg, div_next;
  logic [7:0]  lfsr_reg, lfsr_next;
  logic        gap_reg, gap_next;

  logic [7:0]  one_hot;
  logic [7:0]  new_row;
  logic        lfsr_fb;
  logic        paused;
  logic        tick;
  logic [15:0] score_inc;
  logic [31:0] div_dec;

  // One-hot column select for the incoming row, driven by the low LFSR bits.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      assign one_hot[gi] = (lfsr_reg[2:0] == 3'(gi));
    end
  endgenerate

  assign new_row   = gap_reg ? 8'h00 : one_hot;
  assign lfsr_fb   = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  // >= rather than == so a period shortened mid-count still fires promptly.
  assign tick      = (cnt_reg >= div_reg - 32'd1);
  assign score_inc = score_reg + 16'd1;
  assign div_dec   = (div_reg >= MIN_C + STEP_C) ? (div_reg - STEP_C) : MIN_C;

`ifdef PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  // Next-state and datapath decisions; gameover outranks a coincident step.
  always_comb begin
    state_next  = state_reg;
    blocks_next = blocks_reg;
    score_next  = score_reg;
    step_next   = 1'b0;
    cnt_next    = cnt_reg;
    div_next    = div_reg;
    lfsr_next   = lfsr_reg;
    gap_next    = gap_reg;

    case (state_reg)
      IDLE, OVER: begin
        if (bus.start) begin
          // Fresh game: clear the field and speed, keep the LFSR running.
          state_next  = RUN;
          blocks_next = '0;
          score_next  = '0;
          cnt_next    = '0;
          div_next    = TICK_C;
          gap_next    = 1'b0;
        end
      end
      RUN: begin
        if (bus.gameover) begin
          state_next = OVER;
        end else if (!paused) begin
          if (tick) begin
            cnt_next    = '0;
            step_next   = 1'b1;
            blocks_next = {new_row, blocks_reg[63:8]};
            lfsr_next   = {lfsr_reg[6:0], lfsr_fb};
            gap_next    = ~gap_reg;
            // A row leaving the bottom with blocks in it was survived.
            if ((blocks_reg[7:0] != 8'h00) && (score_reg != 16'hFFFF)) begin
              score_next = score_inc;
              if (score_inc[2:0] == 3'd0) begin
                div_next = div_dec;
              end
            end
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    running_next = (state_next == RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      blocks_reg  <= '0;
      score_reg   <= '0;
      step_reg    <= 1'b0;
      running_reg <= 1'b0;
      cnt_reg     <= '0;
      div_reg     <= TICK_C;
      lfsr_reg    <= SEED_EFF;
      gap_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      blocks_reg  <= blocks_next;
      score_reg   <= score_next;
      step_reg    <= step_next;
      running_reg <= running_next;
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      lfsr_reg    <= lfsr_next;
      gap_reg     <= gap_next;
    end
  end

  assign bus.blocks  = blocks_reg;
  assign bus.score   = score_reg;
  assign bus.step    = step_reg;
  assign bus.running = running_reg;

endmodule

// File: tb/tb_block_scroller.sv
// Scoreboard bench for block_scroller (TICK_DIV=4, MIN_DIV=2, STEP_DIV=1).
// The stimulus process queues the expected field/score/interval of each
// shift; the monitor pops and compares whenever step is seen.
`timescale 1ns/1ps
module tb_block_scroller;
  localparam int TICKV = 4;
  localparam int MINV  = 2;
  localparam int STEPV = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  block_scroller_if bus();
  block_scroller_if bus0();

  block_scroller #(.TICK_DIV(TICKV), .MIN_DIV(MINV), .STEP_DIV(STEPV), .LFSR_SEED(8'hA5))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  block_scroller #(.TICK_DIV(TICKV), .MIN_DIV(MINV), .STEP_DIV(STEPV), .LFSR_SEED(8'h00))
    dut_s0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  typedef struct {
    logic [63:0] blocks;
    logic [15:0] score;
    int          period;
    int          idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ref_cyc = 0;
  int   last_int = 0;

  // Reference model state (per shift, not per cycle).
  logic [63:0] m_blocks;
  logic [15:0] m_score;
  int          m_div;
  logic [7:0]  m_lfsr;
  bit          m_gap;
  int          m_shift;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endfunction

  function automatic logic [7:0] lfsr_adv(logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic void model_start();
    m_blocks = '0;
    m_score  = '0;
    m_div    = TICKV;
    m_gap    = 1'b0;
    m_shift  = 0;
  endfunction

  // Predict one shift and queue it; extra adds paused cycles to the interval.
  function automatic void push_shift(int extra);
    exp_t       e;
    logic [7:0] row;
    int         per;
    per = m_div + extra;
    row = m_gap ? 8'h00 : (8'h01 << m_lfsr[2:0]);
    if (m_blocks[7:0] != 8'h00 && m_score != 16'hFFFF) begin
      m_score = m_score + 16'd1;
      if (m_score[2:0] == 3'd0)
        m_div = (m_div - STEPV < MINV) ? MINV : m_div - STEPV;
    end
    m_blocks = {row, m_blocks[63:8]};
    m_lfsr   = lfsr_adv(m_lfsr);
    m_gap    = !m_gap;
    m_shift++;
    e.blocks = m_blocks;
    e.score  = m_score;
    e.period = per;
    e.idx    = m_shift;
    sb_q.push_back(e);
  endfunction

  function automatic void push_n(int n);
    for (int i = 0; i < n; i++) push_shift(0);
  endfunction

  task automatic wait_drain(int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  // Monitor: time each step from the previous step (or accepted start).
  initial begin
    exp_t e;
    int   iv;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst && bus.start && !bus.running) ref_cyc = cyc;
      #1;
      if (bus.step) begin
        iv       = cyc - ref_cyc;
        ref_cyc  = cyc;
        last_int = iv;
        if (sb_q.size() == 0) begin
          chk("unexpected_step", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          $display("shift %0d: blocks=%h score=%0d interval=%0d", e.idx, bus.blocks, bus.score, iv);
          chk($sformatf("blocks_s%0d", e.idx), bus.blocks, e.blocks);
          chk($sformatf("score_s%0d", e.idx), 64'(bus.score), 64'(e.score));
          chk($sformatf("interval_s%0d", e.idx), 64'(iv), 64'(e.period));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;  bus.gameover = 1'b0;
    bus0.start = 1'b0; bus0.gameover = 1'b0;
`ifdef PAUSE_EN
    bus.pause = 1'b0;  bus0.pause = 1'b0;
`endif
    m_lfsr = 8'hA5;
    model_start();

    // Reset for two cycles.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_blocks", bus.blocks, 64'd0);
    chk("rst_score", 64'(bus.score), 64'd0);
    chk("rst_running", 64'(bus.running), 64'd0);
    chk("rst_step", 64'(bus.step), 64'd0);
    chk("rst_blocks_seed0", bus0.blocks, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    $display("start game");

    bus.start = 1'b1; bus0.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus0.start = 1'b0;
    model_start();
    chk("start_running", 64'(bus.running), 64'd1);
    chk("start_step", 64'(bus.step), 64'd0);

    // First shift: one-hot top row, then an empty row.
    push_n(1); wait_drain(50);
    chk("shift1_blocks", bus.blocks, 64'h2000_0000_0000_0000);
    chk("first_latency", 64'(last_int), 64'd4);
    push_n(1); wait_drain(50);
    chk("shift2_blocks", bus.blocks, 64'h0020_0000_0000_0000);
    push_n(5); wait_drain(100);
    chk("shift7_blocks", bus.blocks, 64'h0800_1000_2000_2000);
    chk("shift7_blocks_seed0", bus0.blocks, 64'h2000_2000_2000_2000);

    // Speed-up at 8 and 16 points, floor at MIN_DIV.
    push_n(16); wait_drain(200);
    chk("score_at_s23", 64'(bus.score), 64'd8);
    push_n(1); wait_drain(50);
    chk("period_after_8", 64'(last_int), 64'd3);
    push_n(15); wait_drain(200);
    chk("score_at_s39", 64'(bus.score), 64'd16);
    push_n(1); wait_drain(50);
    chk("period_after_16", 64'(last_int), 64'd2);
    push_n(16); wait_drain(200);
    chk("score_at_s56", 64'(bus.score), 64'd24);
    chk("period_floor", 64'(last_int), 64'd2);

    // Gameover on the very edge a step would fire.
    $display("gameover on step edge");
    repeat (m_div - 1) @(negedge clk);
    bus.gameover = 1'b1;
    @(negedge clk);
    chk("go_running", 64'(bus.running), 64'd0);
    chk("go_step", 64'(bus.step), 64'd0);
    chk("go_blocks", bus.blocks, m_blocks);
    chk("go_score", 64'(bus.score), 64'd24);
    repeat (6) @(negedge clk);
    chk("over_blocks_frozen", bus.blocks, m_blocks);
    chk("over_score_frozen", 64'(bus.score), 64'd24);

    // Restart with start and gameover together.
    $display("restart from OVER");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.gameover = 1'b0;
    model_start();
    chk("restart_running", 64'(bus.running), 64'd1);
    chk("restart_blocks", bus.blocks, 64'd0);
    chk("restart_score", 64'(bus.score), 64'd0);
    push_n(3); wait_drain(100);
    chk("restart_period", 64'(last_int), 64'd4);

    // Start while running is ignored (interval and field carry on).
    $display("start during RUN");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_run_running", 64'(bus.running), 64'd1);
    push_n(2); wait_drain(100);

`ifdef PAUSE_EN
    // Pause for ten cycles, then resume from the held count.
    $display("pause 10 cycles");
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("pause_blocks_%0d", i), bus.blocks, m_blocks);
    end
    bus.pause = 1'b0;
    push_shift(10);
    push_shift(0);
    wait_drain(100);
`endif

    // Reset in mid-game.
    $display("reset mid-game");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_blocks", bus.blocks, 64'd0);
    chk("midrst_score", 64'(bus.score), 64'd0);
    chk("midrst_running", 64'(bus.running), 64'd0);
    chk("midrst_step", 64'(bus.step), 64'd0);
    repeat (10) @(negedge clk);
    chk("idle_blocks", bus.blocks, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
